// File: rtl/enc_pkg.sv
// Shared widths, LFSR taps, FSM states and packet layout for the frame encryption scheduler.
package enc_pkg;

  localparam int unsigned DATA_W = 60;
  localparam int unsigned KEY_W  = 11;
  localparam int unsigned TAG_W  = 6;
  localparam int unsigned SUM_W  = DATA_W + 1;
  localparam int unsigned PKT_W  = 78;
  localparam int unsigned CNT_W  = 10;

  localparam int unsigned KEY_TAP_HI = 10;
  localparam int unsigned KEY_TAP_LO = 8;
  localparam int unsigned TAG_TAP_HI = 5;
  localparam int unsigned TAG_TAP_LO = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic [SUM_W-1:0] sum;
    logic [TAG_W-1:0] tag;
  } pkt_t;

  // Fibonacci steps: shift left, feedback enters bit 0
  function automatic logic [KEY_W-1:0] key_step(input logic [KEY_W-1:0] k);
    return {k[KEY_W-2:0], k[KEY_TAP_HI] ^ k[KEY_TAP_LO]};
  endfunction

  function automatic logic [TAG_W-1:0] tag_step(input logic [TAG_W-1:0] t);
    return {t[TAG_W-2:0], t[TAG_TAP_HI] ^ t[TAG_TAP_LO]};
  endfunction

endpackage

// File: rtl/enc_mask_add.sv
// Expands the 11-bit key into a 60-bit mask and adds it to the plaintext, keeping the carry.
module enc_mask_add
  import enc_pkg::*;
(
  input  logic [KEY_W-1:0]  i_key,
  input  logic [DATA_W-1:0] i_data,
  output logic [SUM_W-1:0]  o_sum_c
);

  logic [DATA_W-1:0] w_mask;

  assign w_mask  = {i_key[4:0], i_key, ~i_key, ~i_key, i_key, i_key};
  assign o_sum_c = SUM_W'(i_data) + SUM_W'(w_mask);

endmodule

// File: rtl/enc_frame_scheduler.sv
// Word-at-a-time encryption scheduler with LFSR key/tag and periodic rekey.
// Optional statistics counters enabled by defining ENC_FRAME_SCHED_STATS_EN.
module enc_frame_scheduler
  import enc_pkg::*;
#(
  parameter int unsigned      REKEY_INTERVAL = 16,
  parameter logic [KEY_W-1:0] SEED_11        = 11'h5A3,
  parameter logic [TAG_W-1:0] SEED_6         = 6'h2B
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PKT_W-1:0]  out_data,
  input  logic              seed_load,
  input  logic [KEY_W-1:0]  seed_11,
  input  logic [TAG_W-1:0]  seed_6,
  output logic              busy,
  output logic              rekey_pulse
`ifdef ENC_FRAME_SCHED_STATS_EN
  ,
  output logic [31:0]       pkt_count,
  output logic [15:0]       rekey_count
`endif
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(REKEY_INTERVAL - 1);

  state_e            r_state;
  logic [KEY_W-1:0]  r_key;
  logic [TAG_W-1:0]  r_tag;
  logic [CNT_W-1:0]  r_word_cnt;
  logic [DATA_W-1:0] r_data;
  logic              r_out_valid;
  pkt_t              r_out_data;
  logic              r_rekey_pulse;

  logic [SUM_W-1:0]  w_sum;
  logic              w_handshake;
  logic              w_rekey;
  logic              w_seed_load;
  logic [KEY_W-1:0]  w_seed_key;
  logic [TAG_W-1:0]  w_seed_tag;

  enc_mask_add u_mask_add (
    .i_key   (r_key),
    .i_data  (r_data),
    .o_sum_c (w_sum)
  );

  assign w_handshake = (r_state == ST_OUT) && out_ready;
  assign w_rekey     = w_handshake && (r_word_cnt == LAST_CNT);
  assign w_seed_load = (r_state == ST_IDLE) && seed_load;
  // An all-zero seed would lock the LFSR, so it is replaced by 1
  assign w_seed_key  = (seed_11 == '0) ? KEY_W'(1) : seed_11;
  assign w_seed_tag  = (seed_6 == '0) ? TAG_W'(1) : seed_6;

  assign in_ready    = (r_state == ST_IDLE) && !seed_load;
  assign busy        = (r_state != ST_IDLE);
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign rekey_pulse = r_rekey_pulse;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state       <= ST_IDLE;
      r_key         <= SEED_11;
      r_tag         <= SEED_6;
      r_word_cnt    <= '0;
      r_data        <= '0;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_rekey_pulse <= 1'b0;
    end else begin
      r_rekey_pulse <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (seed_load) begin
            r_key      <= w_seed_key;
            r_tag      <= w_seed_tag;
            r_word_cnt <= '0;
          end else if (in_valid) begin
            r_data  <= in_data;
            r_state <= ST_CALC;
          end
        end
        ST_CALC: begin
          r_out_data  <= '{key: r_key, sum: w_sum, tag: r_tag};
          r_out_valid <= 1'b1;
          r_state     <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_tag       <= tag_step(r_tag);
            if (w_rekey) begin
              r_key         <= key_step(r_key);
              r_word_cnt    <= '0;
              r_rekey_pulse <= 1'b1;
            end else begin
              r_word_cnt <= r_word_cnt + CNT_W'(1);
            end
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef ENC_FRAME_SCHED_STATS_EN
  logic [31:0] r_pkt_count;
  logic [15:0] r_rekey_count;

  // Free-running wrap counters, cleared alongside a seed reload
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_pkt_count   <= '0;
      r_rekey_count <= '0;
    end else if (w_seed_load) begin
      r_pkt_count   <= '0;
      r_rekey_count <= '0;
    end else begin
      if (w_handshake) r_pkt_count <= r_pkt_count + 32'(1);
      if (w_rekey)     r_rekey_count <= r_rekey_count + 16'(1);
    end
  end

  assign pkt_count   = r_pkt_count;
  assign rekey_count = r_rekey_count;
`endif

endmodule

// File: tb/tb_enc_frame_scheduler.sv
// Directed self-checking bench for enc_frame_scheduler (REKEY_INTERVAL=4, default seeds).
module tb_enc_frame_scheduler;

  logic        Clk;
  logic        Rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [59:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [77:0] out_data;
  logic        seed_load;
  logic [10:0] seed_11;
  logic [5:0]  seed_6;
  logic        busy;
  logic        rekey_pulse;
`ifdef ENC_FRAME_SCHED_STATS_EN
  logic [31:0] pkt_count;
  logic [15:0] rekey_count;
`endif

  int n_pass  = 0;
  int n_total = 0;

  enc_frame_scheduler #(
    .REKEY_INTERVAL (4),
    .SEED_11        (11'h5A3),
    .SEED_6         (6'h2B)
  ) dut (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .seed_load   (seed_load),
    .seed_11     (seed_11),
    .seed_6      (seed_6),
    .busy        (busy),
    .rekey_pulse (rekey_pulse)
`ifdef ENC_FRAME_SCHED_STATS_EN
    ,
    .pkt_count   (pkt_count),
    .rekey_count (rekey_count)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Push one word with out_ready high; returns the packet and the following-cycle rekey_pulse
  task automatic xfer(input logic [59:0] d, output logic [77:0] pkt, output logic pulse);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge Clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 8) begin
      @(negedge Clk);
      n++;
    end
    check("xfer_out_valid", 128'(out_valid), 128'(1));
    pkt = out_data;
    @(negedge Clk);
    pulse = rekey_pulse;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [77:0] pkt;
    logic        pulse;
    logic [10:0] exp_key [3];
    logic [77:0] held_pkt;
    exp_key[0] = 11'h5A3;
    exp_key[1] = 11'h346;
    exp_key[2] = 11'h68D;
    held_pkt = {11'h7FF, 61'h0FFFF00000400004, 6'h3C};

    Rst_n = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    seed_load = 1'b0; seed_11 = '0; seed_6 = '0;
    #2 Rst_n = 1'b0;
    repeat (2) @(negedge Clk);
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_data", 128'(out_data), 128'(0));
    check("rst_rekey_pulse", 128'(rekey_pulse), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(1));
    Rst_n = 1'b1;
    @(negedge Clk);

    // Rekey every 4 words from the reset seed
    for (int i = 0; i < 9; i++) begin
      xfer(60'(i * 3 + 1), pkt, pulse);
      check("grp_key", 128'(pkt[77:67]), 128'(exp_key[i / 4]));
      check("grp_pulse", 128'(pulse), 128'((i == 3 || i == 7) ? 1 : 0));
      if (i == 0) check("first_tag", 128'(pkt[5:0]), 128'(6'h2B));
    end
    @(negedge Clk);
    check("pulse_one_cycle", 128'(rekey_pulse), 128'(0));

    // seed_load beats in_valid; zero seeds become 1
    seed_load = 1'b1; seed_11 = 11'h000; seed_6 = 6'h00;
    in_valid = 1'b1; in_data = 60'h123;
    #1;
    check("seed_in_ready", 128'(in_ready), 128'(0));
    @(negedge Clk);
    seed_load = 1'b0; in_valid = 1'b0;
    check("seed_not_accepted", 128'(busy), 128'(0));
    @(negedge Clk);
    check("seed_still_idle", 128'(busy), 128'(0));
    xfer(60'h0, pkt, pulse);
    check("zero_seed_key", 128'(pkt[77:67]), 128'(11'h001));
    check("zero_seed_tag", 128'(pkt[5:0]), 128'(6'h01));
    check("zero_seed_pulse", 128'(pulse), 128'(0));

    // All-ones seeds, zero data, latency check
    seed_load = 1'b1; seed_11 = 11'h7FF; seed_6 = 6'h3F;
    @(negedge Clk);
    seed_load = 1'b0;
    in_valid = 1'b1; in_data = '0;
    @(negedge Clk);
    in_valid = 1'b0;
    check("lat_valid_c1", 128'(out_valid), 128'(0));
    check("lat_busy_c1", 128'(busy), 128'(1));
    check("lat_in_ready_c1", 128'(in_ready), 128'(0));
    @(negedge Clk);
    check("lat_valid_c2", 128'(out_valid), 128'(1));
    check("t1_key", 128'(out_data[77:67]), 128'(11'h7FF));
    check("t1_sum", 128'(out_data[66:6]), 128'(61'h0FFFF000003FFFFF));
    check("t1_tag", 128'(out_data[5:0]), 128'(6'h3F));
    @(negedge Clk);
    check("t1_valid_drop", 128'(out_valid), 128'(0));

    xfer(60'hFFFFFFFFFFFFFFF, pkt, pulse);
    check("t2_sum_carry", 128'(pkt[66:6]), 128'(61'h1FFFF000003FFFFE));
    check("t2_tag", 128'(pkt[5:0]), 128'(6'h3E));

    // Backpressure: packet must hold with no LFSR movement
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 60'h5;
    @(negedge Clk);
    in_valid = 1'b0;
    @(negedge Clk);
    for (int c = 0; c < 5; c++) begin
      check("bp_valid", 128'(out_valid), 128'(1));
      check("bp_data", 128'(out_data), 128'(held_pkt));
      check("bp_in_ready", 128'(in_ready), 128'(0));
      @(negedge Clk);
    end
    out_ready = 1'b1;
    @(negedge Clk);
    check("bp_release_valid", 128'(out_valid), 128'(0));
    check("bp_release_pulse", 128'(rekey_pulse), 128'(0));

    xfer(60'h0, pkt, pulse);
    check("w4_tag", 128'(pkt[5:0]), 128'(6'h38));
    check("w4_key", 128'(pkt[77:67]), 128'(11'h7FF));
    check("w4_pulse", 128'(pulse), 128'(1));
    xfer(60'h0, pkt, pulse);
    check("w5_key", 128'(pkt[77:67]), 128'(11'h7FE));
    check("w5_tag", 128'(pkt[5:0]), 128'(6'h30));

    // Reset while the word sits in CALC
    in_valid = 1'b1; in_data = 60'h1;
    @(negedge Clk);
    in_valid = 1'b0;
    check("pre_rst_busy", 128'(busy), 128'(1));
    #1 Rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 128'(out_valid), 128'(0));
    check("mid_rst_busy", 128'(busy), 128'(0));
    @(negedge Clk);
    Rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge Clk);
      check("post_rst_no_pkt", 128'(out_valid), 128'(0));
    end
    xfer(60'h0, pkt, pulse);
    check("post_rst_key", 128'(pkt[77:67]), 128'(11'h5A3));
    check("post_rst_tag", 128'(pkt[5:0]), 128'(6'h2B));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
